// File: rtl/boot_load_controller.sv
// Program-load controller: accepts a valid/ready word stream, writes it into instruction
// memory and holds the processor in reset until the load and a hold delay complete.
module boot_load_controller #(
  parameter int unsigned          ADDR_W    = 20,
  parameter int unsigned          DATA_W    = 16,
  parameter int unsigned          MAX_WORDS = 1024,
  parameter int unsigned          AUTO_ADDR = 1,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
  parameter int unsigned          HOLD_CYC  = 4,
  localparam int unsigned         CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic [ADDR_W-1:0] instrWriteAddress,
  output logic [DATA_W-1:0] instrWriteData,
  output logic              instrWriteEnable,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              err_overflow,
  output logic [CNT_W-1:0]  word_count
);

  localparam int unsigned HCNT_W = $clog2(HOLD_CYC + 1);

  typedef enum logic [1:0] {StLoad, StHold, StRun, StError} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    wc_q, wc_d;
  logic [HCNT_W-1:0]   hold_q, hold_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                we_q, we_d;
  logic                ready_q, ready_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                hs;
  logic [CNT_W-1:0]    wc_inc;

  assign hs     = s_valid & ready_q;
  assign wc_inc = wc_q + 1'b1;

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    hold_d  = hold_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (hs) begin
          we_d   = 1'b1;
          addr_d = (AUTO_ADDR != 0) ? BASE_ADDR + ADDR_W'(wc_q) : s_addr;
          data_d = s_data;
          wc_d   = wc_inc;
          // s_last takes priority so a load of exactly MAX_WORDS is legal
          if (s_last) begin
            state_d = StHold;
            hold_d  = '0;
          end else if (wc_inc == CNT_W'(MAX_WORDS)) begin
            state_d = StError;
          end
        end
      end
      StHold: begin
        if (hold_q == HCNT_W'(HOLD_CYC)) begin
          state_d = StRun;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StRun, StError: begin
        if (load_start) begin
          state_d = StLoad;
          wc_d    = '0;
        end
      end
      default: state_d = StLoad;
    endcase
    // Status outputs are registered from the next state so they track state_q exactly
    ready_d   = (state_d == StLoad);
    cpu_rst_d = (state_d != StRun);
    done_d    = (state_d == StRun);
    err_d     = (state_d == StError);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StLoad;
      wc_q      <= '0;
      hold_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      ready_q   <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wc_q      <= wc_d;
      hold_q    <= hold_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
      ready_q   <= ready_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign s_ready           = ready_q;
  assign instrWriteAddress = addr_q;
  assign instrWriteData    = data_q;
  assign instrWriteEnable  = we_q;
  assign cpu_reset         = cpu_rst_q;
  assign load_done         = done_q;
  assign err_overflow      = err_q;
  assign word_count        = wc_q;

endmodule

// File: tb/tb_boot_load_controller.sv
// Directed bench for boot_load_controller: auto-address instance (BASE 0x100, 4-word limit)
// and an explicit-address instance sharing the same stimulus.
module tb_boot_load_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic        s_valid = 1'b0;
  logic [19:0] s_addr = '0;
  logic [15:0] s_data = '0;
  logic        s_last = 1'b0;

  logic        s_ready, we, cpu_reset, load_done, err_overflow;
  logic [19:0] waddr;
  logic [15:0] wdata;
  logic [2:0]  word_count;

  logic        b_s_ready, b_we, b_cpu_reset, b_load_done, b_err_overflow;
  logic [19:0] b_waddr;
  logic [15:0] b_wdata;
  logic [10:0] b_word_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  boot_load_controller #(
    .ADDR_W(20), .DATA_W(16), .MAX_WORDS(4), .AUTO_ADDR(1), .BASE_ADDR(20'h00100),
    .HOLD_CYC(4)
  ) dut_a (
    .clk(clk), .reset(reset), .load_start(load_start), .s_valid(s_valid),
    .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data), .s_last(s_last),
    .instrWriteAddress(waddr), .instrWriteData(wdata), .instrWriteEnable(we),
    .cpu_reset(cpu_reset), .load_done(load_done), .err_overflow(err_overflow),
    .word_count(word_count)
  );

  boot_load_controller #(
    .ADDR_W(20), .DATA_W(16), .MAX_WORDS(1024), .AUTO_ADDR(0), .BASE_ADDR(20'h00000),
    .HOLD_CYC(4)
  ) dut_b (
    .clk(clk), .reset(reset), .load_start(load_start), .s_valid(s_valid),
    .s_ready(b_s_ready), .s_addr(s_addr), .s_data(s_data), .s_last(s_last),
    .instrWriteAddress(b_waddr), .instrWriteData(b_wdata), .instrWriteEnable(b_we),
    .cpu_reset(b_cpu_reset), .load_done(b_load_done), .err_overflow(b_err_overflow),
    .word_count(b_word_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [19:0] a, input logic [15:0] d, input logic last);
    s_valid = 1'b1;
    s_addr  = a;
    s_data  = d;
    s_last  = last;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Cycles until cpu_reset falls, bounded at 20
  task automatic wait_release(output int n);
    n = 0;
    while (cpu_reset === 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    checks++;
    if ({s_ready, cpu_reset, we, load_done, err_overflow} !== 5'b01000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=01000",
               {s_ready, cpu_reset, we, load_done, err_overflow});
    end
    checks++;
    if ({waddr, wdata, word_count} !== '0) begin
      failures++;
      $display("FAIL reset_regs addr=%h data=%h wc=%0d exp=0", waddr, wdata, word_count);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_release got=%b exp=1", s_ready);
    end
  endtask

  task automatic test_auto_load();
    int n;
    logic [15:0] dv [3];
    dv[0] = 16'h1111; dv[1] = 16'h2222; dv[2] = 16'h3333;
    for (int i = 0; i < 3; i++) begin
      send(20'h0, dv[i], (i == 2));
      checks++;
      if (we !== 1'b1 || waddr !== 20'h00100 + 20'(i) || wdata !== dv[i]
          || word_count !== 3'(i + 1)) begin
        failures++;
        $display("FAIL auto_write%0d we=%b addr=%h data=%h wc=%0d exp we=1 addr=%h data=%h wc=%0d",
                 i, we, waddr, wdata, word_count, 20'h00100 + 20'(i), dv[i], i + 1);
      end
    end
    checks++;
    if (s_ready !== 1'b0 || cpu_reset !== 1'b1) begin
      failures++;
      $display("FAIL auto_hold_entry ready=%b cpu_reset=%b exp 0/1", s_ready, cpu_reset);
    end
    tick();
    checks++;
    if (we !== 1'b0) begin
      failures++;
      $display("FAIL auto_strobe_width we=%b exp=0", we);
    end
    wait_release(n);
    checks++;
    if (n + 1 !== 5) begin
      failures++;
      $display("FAIL auto_hold_len got=%0d exp=5", n + 1);
    end
    checks++;
    if (load_done !== 1'b1 || word_count !== 3'd3 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL auto_run done=%b wc=%0d ready=%b exp 1/3/0", load_done, word_count, s_ready);
    end
  endtask

  task automatic test_reload();
    int n;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checks++;
    if ({cpu_reset, load_done, s_ready} !== 3'b101 || word_count !== 3'd0) begin
      failures++;
      $display("FAIL reload_entry cpu=%b done=%b ready=%b wc=%0d exp 1/0/1/0",
               cpu_reset, load_done, s_ready, word_count);
    end
    send(20'h0, 16'hAAAA, 1'b0);
    checks++;
    if (we !== 1'b1 || waddr !== 20'h00100 || wdata !== 16'hAAAA) begin
      failures++;
      $display("FAIL reload_w0 we=%b addr=%h data=%h exp 1/00100/aaaa", we, waddr, wdata);
    end
    send(20'h0, 16'hBBBB, 1'b1);
    checks++;
    if (waddr !== 20'h00101 || wdata !== 16'hBBBB || word_count !== 3'd2) begin
      failures++;
      $display("FAIL reload_w1 addr=%h data=%h wc=%0d exp 00101/bbbb/2", waddr, wdata, word_count);
    end
    wait_release(n);
    checks++;
    if (n !== 5 || load_done !== 1'b1) begin
      failures++;
      $display("FAIL reload_run cycles=%0d done=%b exp 5/1", n, load_done);
    end
  endtask

  task automatic test_explicit_addr();
    do_reset();
    send(20'hFFFFF, 16'h0F0F, 1'b0);
    checks++;
    if (b_we !== 1'b1 || b_waddr !== 20'hFFFFF || b_wdata !== 16'h0F0F) begin
      failures++;
      $display("FAIL expl_w0 we=%b addr=%h data=%h exp 1/fffff/0f0f", b_we, b_waddr, b_wdata);
    end
    s_addr = 20'h12345;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (b_we !== 1'b0) begin
        failures++;
        $display("FAIL expl_gap%0d we=%b exp=0", i, b_we);
      end
    end
    send(20'h00005, 16'h5A5A, 1'b1);
    checks++;
    if (b_we !== 1'b1 || b_waddr !== 20'h00005 || b_word_count !== 11'd2) begin
      failures++;
      $display("FAIL expl_w1 we=%b addr=%h wc=%0d exp 1/00005/2", b_we, b_waddr, b_word_count);
    end
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    for (int i = 0; i < 4; i++) send(20'h0, 16'(i), 1'b0);
    checks++;
    if ({err_overflow, cpu_reset, s_ready, we} !== 4'b1101 || word_count !== 3'd4) begin
      failures++;
      $display("FAIL ovf_enter err=%b cpu=%b ready=%b we=%b wc=%0d exp 1/1/0/1/4",
               err_overflow, cpu_reset, s_ready, we, word_count);
    end
    s_valid = 1'b1;
    tick();
    tick();
    s_valid = 1'b0;
    checks++;
    if ({err_overflow, cpu_reset, s_ready, we, load_done} !== 5'b11000) begin
      failures++;
      $display("FAIL ovf_stay err=%b cpu=%b ready=%b we=%b done=%b exp 1/1/0/0/0",
               err_overflow, cpu_reset, s_ready, we, load_done);
    end
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checks++;
    if ({err_overflow, s_ready} !== 2'b01 || word_count !== 3'd0) begin
      failures++;
      $display("FAIL ovf_exit err=%b ready=%b wc=%0d exp 0/1/0", err_overflow, s_ready, word_count);
    end
    for (int i = 0; i < 4; i++) send(20'h0, 16'(i), (i == 3));
    checks++;
    if ({err_overflow, s_ready, we} !== 3'b001 || waddr !== 20'h00103) begin
      failures++;
      $display("FAIL exact_max err=%b ready=%b we=%b addr=%h exp 0/0/1/00103",
               err_overflow, s_ready, we, waddr);
    end
    wait_release(n);
    checks++;
    if (load_done !== 1'b1 || err_overflow !== 1'b0 || n !== 5) begin
      failures++;
      $display("FAIL exact_run done=%b err=%b cycles=%0d exp 1/0/5", load_done, err_overflow, n);
    end
  endtask

  task automatic test_reset_midload();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    send(20'h0, 16'hC001, 1'b0);
    send(20'h0, 16'hC002, 1'b0);
    s_valid = 1'b1;
    s_data  = 16'hC003;
    reset   = 1'b0;
    tick();
    s_valid = 1'b0;
    checks++;
    if ({s_ready, cpu_reset, we, load_done, err_overflow} !== 5'b01000
        || {waddr, wdata, word_count} !== '0) begin
      failures++;
      $display("FAIL midreset flags=%b addr=%h data=%h wc=%0d exp 01000/0/0/0",
               {s_ready, cpu_reset, we, load_done, err_overflow}, waddr, wdata, word_count);
    end
    reset = 1'b1;
    tick();
    send(20'h0, 16'hD001, 1'b0);
    checks++;
    if (waddr !== 20'h00100 || word_count !== 3'd1 || we !== 1'b1) begin
      failures++;
      $display("FAIL midreset_restart addr=%h wc=%0d we=%b exp 00100/1/1", waddr, word_count, we);
    end
  endtask

  task automatic test_load_start_ignored();
    int n;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checks++;
    if (word_count !== 3'd1 || s_ready !== 1'b1 || cpu_reset !== 1'b1) begin
      failures++;
      $display("FAIL ignore_load wc=%0d ready=%b cpu=%b exp 1/1/1", word_count, s_ready, cpu_reset);
    end
    send(20'h0, 16'hD002, 1'b1);
    checks++;
    if (waddr !== 20'h00101 || word_count !== 3'd2) begin
      failures++;
      $display("FAIL ignore_w1 addr=%h wc=%0d exp 00101/2", waddr, word_count);
    end
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    wait_release(n);
    checks++;
    if (n + 1 !== 5 || load_done !== 1'b1 || word_count !== 3'd2) begin
      failures++;
      $display("FAIL ignore_hold cycles=%0d done=%b wc=%0d exp 5/1/2", n + 1, load_done,
               word_count);
    end
  endtask

  initial begin
    test_reset();
    test_auto_load();
    test_reload();
    test_explicit_addr();
    test_overflow();
    test_reset_midload();
    test_load_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
